ys_poly_small_seq: RTL

YS_POLY_SMALL_SEQ -- requirements
Module: ys_poly_small_seq

---
 rtl/ys_poly_small_seq_pkg.sv | 17 +
 rtl/ys_poly_small_dly.sv | 54 +++++
 rtl/ys_poly_small_seq.sv | 119 +++++++++++
 3 files changed

// File: rtl/ys_poly_small_seq_pkg.sv
// Shared poly_small definitions: sequencer state encoding, geometry defaults
// and datapath word widths.
package ys_poly_small_seq_pkg;

    localparam int WORDS_DEF = 64;
    localparam int AW_DEF    = 8;
    localparam int DW_13     = 13;
    localparam int DW_PH     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/ys_poly_small_dly.sv
// RD_LAT-stage delay line carrying the read strobe, word index and
// first-pair flag across the RAM1 read latency.
module ys_poly_small_dly #(
    parameter int RD_LAT = 1,
    parameter int AW     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [AW-1:0] in_idx,
    input  logic          in_first,
    output logic          out_valid,
    output logic [AW-1:0] out_idx,
    output logic          out_first
);

    localparam int S = AW + 2;

    logic [RD_LAT*S-1:0] pipe_q;
    logic [S-1:0]        stage_in;
    logic [S-1:0]        stage_out;

    assign stage_in  = {in_valid, in_first, in_idx};
    assign stage_out = pipe_q[RD_LAT*S-1 -: S];

    assign out_valid = stage_out[S-1];
    assign out_first = stage_out[S-2];
    assign out_idx   = stage_out[AW-1:0];

    // Oldest entry sits in the top slice; new entries shift in at the bottom.
    if (RD_LAT == 1) begin : g_single
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_q <= '0;
            end else if (flush) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= stage_in;
            end
        end
    end else begin : g_multi
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_q <= '0;
            end else if (flush) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= {pipe_q[(RD_LAT-1)*S-1:0], stage_in};
            end
        end
    end

endmodule

// File: rtl/ys_poly_small_seq.sv
// poly_small pass sequencer: streams coefficient-pair reads from RAM1 and
// issues the matching RAM2 writes RD_LAT cycles later.
module ys_poly_small_seq
    import ys_poly_small_seq_pkg::*;
#(
    parameter int WORDS  = WORDS_DEF,
    parameter int AW     = AW_DEF,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [1:0]    mode_o,
    output logic          ram1_en,
    output logic [AW-1:0] ram1_addra,
    output logic [AW-1:0] ram1_addrb,
    output logic          ram2_we,
    output logic [AW-1:0] ram2_addra,
    output logic [AW-1:0] ram2_addrb,
    output logic          f_ctr
);

    // state    | meaning
    // ST_IDLE  | waiting for start; mode latched on acceptance
    // ST_READ  | one RAM1 pair read per cycle, k = 0..WORDS-1
    // ST_DRAIN | reads finished, waiting for the last delayed write
    // ST_DONE  | one-cycle done pulse, then back to idle

    if (2 * WORDS > 2 ** AW || WORDS < 1 || AW < 2 || RD_LAT < 1) begin : g_bad_cfg
        $error("ys_poly_small_seq: need 1 <= WORDS, 2*WORDS <= 2**AW, AW >= 2, RD_LAT >= 1");
    end

    localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] k_q;
    logic [1:0]    mode_q;
    logic          rd_en;
    logic          flush;
    logic          accept;
    logic          wr_valid;
    logic [AW-1:0] wr_idx;
    logic          wr_first;

    assign rd_en  = (state_q == ST_READ);
    assign accept = (state_q == ST_IDLE) && start;
    assign flush  = abort && ((state_q == ST_READ) || (state_q == ST_DRAIN));

    ys_poly_small_dly #(
        .RD_LAT (RD_LAT),
        .AW     (AW)
    ) u_dly (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (rd_en),
        .in_idx    (k_q),
        .in_first  (k_q == '0),
        .out_valid (wr_valid),
        .out_idx   (wr_idx),
        .out_first (wr_first)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            mode_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                k_q    <= '0;
                mode_q <= mode;
            end else if (rd_en) begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_READ;
            end
            ST_READ: begin
                if (abort)             state_d = ST_IDLE;
                else if (k_q == LAST)  state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort)                             state_d = ST_IDLE;
                else if (wr_valid && wr_idx == LAST)   state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy   = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done   = (state_q == ST_DONE);
    assign mode_o = mode_q;

    // Addresses are forced to zero whenever the matching strobe is low.
    assign ram1_en    = rd_en;
    assign ram1_addra = rd_en ? {k_q[AW-2:0], 1'b0} : '0;
    assign ram1_addrb = rd_en ? {k_q[AW-2:0], 1'b1} : '0;

    assign ram2_we    = wr_valid;
    assign ram2_addra = wr_valid ? {wr_idx[AW-2:0], 1'b0} : '0;
    assign ram2_addrb = wr_valid ? {wr_idx[AW-2:0], 1'b1} : '0;
    assign f_ctr      = wr_valid && !wr_first;

endmodule
